// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: decode-bus layout and default reset pc.
package fetch_pkg;
  localparam int          F2D_BUS_W    = 65;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
  localparam int          BUS_PC_LSB   = 0;
  localparam int          BUS_INST_LSB = 32;
  localparam int          BUS_ADEF_BIT = 64;

  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } f2d_bus_t;
endpackage

// File: rtl/fetch_ibuf_fifo.sv
// Parametrised synchronous FIFO; head is read straight from storage, so a push
// becomes visible the cycle after it is written. flush beats push and pop.
module fetch_ibuf_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty, full, do_push, do_pop;

  // Explicit wrap so non power-of-two depths (pc queue) also work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (int'(cnt_q) == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = nxt(wptr_q);
      if (do_pop)  rptr_d = nxt(rptr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_buf_stage.sv
// Decoupled instruction fetch: issues sram reads ahead into an instruction buffer.
// FETCH_ADEF_CHECK_EN: misaligned fetch_pc raises adef instead of fetching.
module fetch_buf_stage import fetch_pkg::*; #(
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 inst_sram_req,
  output logic                 inst_sram_wr,
  output logic [1:0]           inst_sram_size,
  output logic [3:0]           inst_sram_wstrb,
  output logic [31:0]          inst_sram_wdata,
  output logic [31:0]          inst_sram_addr,
  input  logic                 inst_sram_addr_ok,
  input  logic                 inst_sram_data_ok,
  input  logic [31:0]          inst_sram_rdata,
  input  logic                 ds_allowin,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 wb_ex,
  input  logic [31:0]          ex_entry,
  input  logic                 ertn_flush,
  input  logic [31:0]          ertn_entry,
  output logic                 fs_to_ds_valid,
  output logic [F2D_BUS_W-1:0] fs_to_ds_bus
);
  localparam int IW = $clog2(IBUF_DEPTH + 1);
  localparam int QW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d, redirect_pc;
  logic [2:0]    outst_q, outst_d, discard_q, discard_d;
  logic          halt_q, halt_d;
  logic          redirect, adef_pc, accept, resp_valid, resp_keep, adef_push;
  logic [IW-1:0] ibuf_cnt;
  logic [QW-1:0] pcq_cnt;
  logic [31:0]   pcq_head;
  f2d_bus_t      ibuf_wdata, ibuf_head;

  always_comb begin
    redirect    = wb_ex | ertn_flush | br_taken;
    redirect_pc = br_target;
    if (wb_ex)           redirect_pc = ex_entry;
    else if (ertn_flush) redirect_pc = ertn_entry;
  end

`ifdef FETCH_ADEF_CHECK_EN
  assign adef_pc        = (fetch_pc_q[1:0] != 2'b00);
  assign inst_sram_addr = fetch_pc_q;
`else
  assign adef_pc        = 1'b0;
  assign inst_sram_addr = {fetch_pc_q[31:2], 2'b00};
`endif

  // Free slots must cover every in-flight response, so a late data_ok always has room.
  assign inst_sram_req = resetn && !redirect && !halt_q && !adef_pc
                       && (int'(outst_q) < MAX_OUTSTANDING)
                       && ((IBUF_DEPTH - int'(ibuf_cnt)) > int'(outst_q));
  assign accept     = inst_sram_req && inst_sram_addr_ok;
  assign resp_valid = inst_sram_data_ok && (outst_q != '0);
  assign resp_keep  = resp_valid && (discard_q == '0) && !redirect && (pcq_cnt != '0);
  assign adef_push  = adef_pc && !halt_q && !redirect && (outst_q == '0)
                    && (int'(ibuf_cnt) < IBUF_DEPTH);

  always_comb begin
    ibuf_wdata = '{adef: 1'b0, inst: inst_sram_rdata, pc: pcq_head};
    if (adef_push) ibuf_wdata = '{adef: 1'b1, inst: 32'h0, pc: fetch_pc_q};
  end

  always_comb begin
    outst_d    = outst_q + 3'(accept) - 3'(resp_valid);
    discard_d  = discard_q;
    halt_d     = halt_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      discard_d  = outst_d;
      halt_d     = 1'b0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (resp_valid && discard_q != '0) discard_d = discard_q - 3'd1;
      if (adef_push) halt_d = 1'b1;
      if (accept)    fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      halt_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      halt_q     <= halt_d;
    end
  end

  fetch_ibuf_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect),
    .push   (accept),
    .wdata  (fetch_pc_q),
    .pop    (resp_keep),
    .rdata  (pcq_head),
    .count  (pcq_cnt)
  );

  fetch_ibuf_fifo #(.WIDTH(F2D_BUS_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect),
    .push   (resp_keep || adef_push),
    .wdata  (ibuf_wdata),
    .pop    (fs_to_ds_valid && ds_allowin),
    .rdata  (ibuf_head),
    .count  (ibuf_cnt)
  );

  assign fs_to_ds_valid  = (ibuf_cnt != '0);
  assign fs_to_ds_bus    = fs_to_ds_valid ? ibuf_head : '0;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_fetch_buf_stage.sv
// Directed bench for fetch_buf_stage with a one-cycle-latency in-order sram model.
module tb_fetch_buf_stage;
  localparam logic [31:0] B   = 32'h1c00_0000;
  localparam logic [31:0] KEY = 32'h5a5a_0000;

  logic        clk, resetn;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata, inst_sram_addr, inst_sram_rdata;
  logic        ds_allowin, br_taken, wb_ex, ertn_flush, fs_to_ds_valid;
  logic [31:0] br_target, ex_entry, ertn_entry;
  logic [64:0] fs_to_ds_bus;

  fetch_buf_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin),
    .br_taken(br_taken), .br_target(br_target), .wb_ex(wb_ex), .ex_entry(ex_entry),
    .ertn_flush(ertn_flush), .ertn_entry(ertn_entry),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          allowin;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  int          tests = 0, fails = 0;
  logic [31:0] pend[$];
  bit          resp_en, s_req, req_seen, mis_seen;
  logic [31:0] s_addr;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive the sram response, sample the request, advance to next negedge.
  task automatic step();
    bit acc;
    inst_sram_data_ok = resp_en && (pend.size() > 0);
    inst_sram_rdata   = inst_sram_data_ok ? (pend[0] ^ KEY) : 32'h0;
    #1;
    s_req  = inst_sram_req;
    s_addr = inst_sram_addr;
    acc    = inst_sram_req && inst_sram_addr_ok;
    req_seen |= s_req;
    mis_seen |= s_req && (s_addr[1:0] != 2'b00);
    @(posedge clk);
    if (inst_sram_data_ok) void'(pend.pop_front());
    if (acc) pend.push_back(s_addr);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    req_seen = 0;
    mis_seen = 0;
    do begin step(); n++; end while (!fs_to_ds_valid && n < 20);
    tests++;
    if (!fs_to_ds_valid) begin
      fails++;
      $display("FAIL %s: valid got 0 after %0d cycles, expected 1", nm, n);
    end
  endtask

  task automatic redirect(input bit ex, input bit er, input bit br,
                          input logic [31:0] t_ex, input logic [31:0] t_er,
                          input logic [31:0] t_br);
    wb_ex = ex; ertn_flush = er; br_taken = br;
    ex_entry = t_ex; ertn_entry = t_er; br_target = t_br;
    step();
    chk("redirect cycle req", 65'(s_req), 65'd0);
    wb_ex = 0; ertn_flush = 0; br_taken = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[20];
    vt[0]  = '{1, 1, B+32'h00, 0, 32'h0};
    vt[1]  = '{1, 1, B+32'h04, 1, B+32'h00};
    vt[2]  = '{1, 1, B+32'h08, 1, B+32'h04};
    vt[3]  = '{1, 1, B+32'h0c, 1, B+32'h08};
    vt[4]  = '{0, 1, B+32'h10, 1, B+32'h08};
    vt[5]  = '{0, 1, B+32'h14, 1, B+32'h08};
    for (int i = 6; i < 14; i++) vt[i] = '{0, 0, 32'h0, 1, B+32'h08};
    vt[14] = '{1, 0, 32'h0,    1, B+32'h0c};
    vt[15] = '{1, 1, B+32'h18, 1, B+32'h10};
    vt[16] = '{1, 1, B+32'h1c, 1, B+32'h14};
    vt[17] = '{1, 1, B+32'h20, 1, B+32'h18};
    vt[18] = '{1, 1, B+32'h24, 1, B+32'h1c};
    vt[19] = '{1, 1, B+32'h28, 1, B+32'h20};

    resetn = 0; ds_allowin = 1; inst_sram_addr_ok = 1; inst_sram_data_ok = 0;
    inst_sram_rdata = 0; br_taken = 0; wb_ex = 0; ertn_flush = 0;
    br_target = 0; ex_entry = 0; ertn_entry = 0;
    resp_en = 1;
    pend.push_back(B + 32'h40);   // stray response while in reset
    @(negedge clk);
    repeat (2) step();
    chk("reset req",   65'(inst_sram_req), 65'd0);
    chk("reset valid", 65'(fs_to_ds_valid), 65'd0);
    chk("reset addr",  65'(inst_sram_addr), 65'(B));
    chk("reset bus",   fs_to_ds_bus, 65'd0);
    chk("reset consts", 65'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
        65'({1'b0, 2'b10, 4'h0, 32'h0}));
    resetn = 1;

    // streaming, then a 10-cycle decode stall and resume
    for (int i = 0; i < 20; i++) begin
      ds_allowin = vt[i].allowin;
      step();
      chk($sformatf("vec%0d req", i), 65'(s_req), 65'(vt[i].req));
      if (vt[i].req) chk($sformatf("vec%0d addr", i), 65'(s_addr), 65'(vt[i].addr));
      chk($sformatf("vec%0d valid", i), 65'(fs_to_ds_valid), 65'(vt[i].valid));
      if (vt[i].valid)
        chk($sformatf("vec%0d bus", i), fs_to_ds_bus, {1'b0, vt[i].pc ^ KEY, vt[i].pc});
    end

    // branch with two stale responses in flight
    resp_en = 0;
    repeat (2) step();
    chk("br setup req", 65'(s_req), 65'd0);
    redirect(0, 0, 1, 32'h0, 32'h0, B + 32'h100);
    resp_en = 1;
    wait_valid("br valid");
    chk("br bus", fs_to_ds_bus, {1'b0, (B + 32'h100) ^ KEY, B + 32'h100});
    step();
    chk("br next bus", fs_to_ds_bus, {1'b0, (B + 32'h104) ^ KEY, B + 32'h104});

    // priority: exception beats branch, ertn beats branch
    redirect(1, 0, 1, B + 32'h200, 32'h0, B + 32'h300);
    wait_valid("ex valid");
    chk("ex wins bus", fs_to_ds_bus, {1'b0, (B + 32'h200) ^ KEY, B + 32'h200});
    redirect(0, 1, 1, 32'h0, B + 32'h400, B + 32'h300);
    wait_valid("ertn valid");
    chk("ertn wins bus", fs_to_ds_bus, {1'b0, (B + 32'h400) ^ KEY, B + 32'h400});
    redirect(1, 1, 1, B + 32'h280, B + 32'h400, B + 32'h300);
    wait_valid("ex3 valid");
    chk("ex3 wins bus", fs_to_ds_bus, {1'b0, (B + 32'h280) ^ KEY, B + 32'h280});

    // misaligned redirect target
    redirect(0, 1, 0, 32'h0, B + 32'h102, 32'h0);
`ifdef FETCH_ADEF_CHECK_EN
    wait_valid("adef valid");
    chk("adef no req", 65'(req_seen), 65'd0);
    chk("adef bus", fs_to_ds_bus, {1'b1, 32'h0, B + 32'h102});
    req_seen = 0;
    repeat (4) step();
    chk("halt no req", 65'(req_seen), 65'd0);
    chk("halt valid",  65'(fs_to_ds_valid), 65'd0);
    redirect(1, 0, 0, B + 32'h500, 32'h0, 32'h0);
    wait_valid("unhalt valid");
    chk("unhalt bus", fs_to_ds_bus, {1'b0, (B + 32'h500) ^ KEY, B + 32'h500});
`else
    wait_valid("unal valid");
    chk("unal addr aligned", 65'(mis_seen), 65'd0);
    chk("unal bus", fs_to_ds_bus, {1'b0, (B + 32'h100) ^ KEY, B + 32'h102});
    step();
    chk("unal next bus", fs_to_ds_bus, {1'b0, (B + 32'h104) ^ KEY, B + 32'h106});
`endif

    // asynchronous reset with two requests outstanding
    resp_en = 0;
    repeat (3) step();
    #2 resetn = 0;
    #1;
    chk("async rst req",   65'(inst_sram_req), 65'd0);
    chk("async rst valid", 65'(fs_to_ds_valid), 65'd0);
    chk("async rst bus",   fs_to_ds_bus, 65'd0);
    chk("async rst addr",  65'(inst_sram_addr), 65'(B));
    @(negedge clk);
    resp_en = 1;
    repeat (3) step();
    resetn = 1;
    step();
    chk("restart req",  65'(s_req), 65'd1);
    chk("restart addr", 65'(s_addr), 65'(B));
    wait_valid("restart valid");
    chk("restart bus", fs_to_ds_bus, {1'b0, B ^ KEY, B});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
